sprite_ctrl: RTL and testbench
==============================

# sprite_ctrl

Frame-rate motion and animation controller for the hedgehog sprite. It sits directly upstream of the sprite engine in the `clk_pix` domain. It consumes the display `frame` pulse and the debounced button signals. It produces the sprite origin (`sprx`, `spry`), the graphic-ROM frame base address (`spr_base_addr`) and a horizontal-mirror flag, all registered and updated once per video frame.

## Interface
- `CORDW`, 16: coordinate width (signed), matches display timings.
- `ADDRW`, 12: sprite ROM address width.
- `SPR_PIXELS`, 640: pixels per graphic frame (32×20).
- `X_MIN`, -132: left turnaround/wrap coordinate (sprite fully off-screen).
- `X_MAX`, 640: right turnaround/wrap coordinate (H_RES).
- `Y_MIN`, 0: top clamp.
- `Y_MAX`, 400: bottom clamp (480 − 20×4).
- `Y_INIT`, 200: reset vertical position.
- `SPEED_X`, 2: horizontal pixels per frame.
- `SPEED_Y`, 2: vertical pixels per frame.

Ports:
- `clk`, input, 1: pixel clock (`clk_pix` at top level).
- `rst`, input, 1: synchronous, active-high reset.
- `frame`, input, 1: one-cycle pulse per video frame.
- `move_up`, input, 1: debounced level, up button held.
- `move_dn`, input, 1: debounced level, down button held.
- `sig_ctrl`, input, 1: one-cycle pulse on ctrl button release.
- `sprx`, output, CORDW signed: sprite left edge.
- `spry`, output, CORDW signed: sprite top line.
- `spr_base_addr`, output, ADDRW: ROM base of current graphic frame.
- `flip`, output, 1: 1 = mirror sprite horizontally (facing right).
- `walking`, output, 1: 1 in WALK_L/WALK_R.

## Operation
- State machine has three states: WALK_L, WALK_R and STOP. A `dir` register (0 = left, 1 = right) holds the last walking direction.
- `sig_ctrl` pulse:
  - WALK_L→STOP and WALK_R→STOP (`dir` kept).
  - STOP→WALK_R if `dir`=0. STOP→WALK_L if `dir`=1. The sprite therefore reverses each time it is resumed.
- All position and animation updates occur only on cycles with `frame`=1, and use the state held before any same-cycle `sig_ctrl` transition.
- Horizontal movement, signed CORDW arithmetic:
  - WALK_L: `sprx > X_MIN` ? `sprx − SPEED_X` : `X_MAX`.
  - WALK_R: `sprx < X_MAX` ? `sprx + SPEED_X` : `X_MIN`.
  - STOP: hold.
- Vertical movement, in any state:
  - `move_up` only: `spry − SPEED_Y`, clamped to ≥ `Y_MIN`.
  - `move_dn` only: `spry + SPEED_Y`, clamped to ≤ `Y_MAX`.
  - Both or neither: hold.
  - Clamping is computed without wrap; any result beyond a limit saturates at that limit.
- Animation counter `cnt` is 6 bits.
  - While walking, `cnt <= cnt+1` on each frame, wrapping 63→0.
  - `spr_base_addr <= SPR_PIXELS × sel(cnt+1)`. `sel` returns 0 for counts 0–15, 1 for 16–31, 0 for 32–47, 2 for 48–63.
  - In STOP, the frame update sets `cnt <= 0` and `spr_base_addr <= 0` (standing pose).
- `flip` = `dir`, registered. `walking` = state ≠ STOP, registered.

## Timing
- Reset values: state WALK_L, `dir`=0, `cnt`=0, `sprx`=`X_MAX`, `spry`=`Y_INIT`, `spr_base_addr`=0, `flip`=0, `walking`=1.
- `rst` has priority over `frame` and `sig_ctrl` in the same cycle. Reset in mid-walk restores all reset values on the next edge.
- Outputs change one clock after a `frame` pulse and are stable for the rest of the frame. `frame` coincides with the start of blanking, so no mid-line change reaches the sprite engine.
- A `sig_ctrl` state change is visible on `walking`/`flip` one clock after the pulse. Its effect on position starts at the next `frame` pulse.
- No handshake; inputs are sampled every clock.

## Test plan
- Reset: hold `rst` for 2 cycles, then one `frame` → `sprx`=638, `spry`=200, `spr_base_addr`=0, `cnt`=1, `flip`=0.
- Left wrap: walk from reset, 386 frames → `sprx`=−132. Next frame → `sprx`=640.
- Animation: 64 walking frames, sampling `spr_base_addr` after each. Values are 0 for the 1st–15th frames, 640 for 16th–31st, 0 for 32nd–47th, 1280 for 48th–63rd, and 0 on the 64th (wrap).
- Stop/reverse: `sig_ctrl` → `walking`=0. Next frame → `sprx` unchanged, `spr_base_addr`=0. Second `sig_ctrl` → `flip`=1, and `sprx` increases by 2 per frame.
- Y clamp: `spry`=1 with `move_up` and one frame → 0. `move_up`+`move_dn` together → no change. `spry`=399 with `move_dn` → 400, held at 400 on further frames.
- Simultaneous `sig_ctrl`+`frame` in WALK_L → `sprx` decrements once, then stays constant in STOP. `rst`+`frame` together → reset values.

Source files
------------

// File: rtl/sprite_ctrl.sv
// Per-frame motion and animation controller for the hedgehog sprite: walks left/right
// with wrap, clamps vertical moves, and selects the ROM graphic frame; all outputs registered.
module sprite_ctrl #(
  parameter int CORDW      = 16,
  parameter int ADDRW      = 12,
  parameter int SPR_PIXELS = 640,
  parameter int X_MIN      = -132,
  parameter int X_MAX      = 640,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 400,
  parameter int Y_INIT     = 200,
  parameter int SPEED_X    = 2,
  parameter int SPEED_Y    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    move_up,
  input  logic                    move_dn,
  input  logic                    sig_ctrl,
  output logic signed [CORDW-1:0] sprx,
  output logic signed [CORDW-1:0] spry,
  output logic [ADDRW-1:0]        spr_base_addr,
  output logic                    flip,
  output logic                    walking
);

  typedef enum logic [1:0] {
    WALK_L = 2'd0,
    WALK_R = 2'd1,
    STOP   = 2'd2
  } state_t;

  localparam logic signed [CORDW-1:0] XMIN_C  = CORDW'(X_MIN);
  localparam logic signed [CORDW-1:0] XMAX_C  = CORDW'(X_MAX);
  localparam logic signed [CORDW-1:0] SPDX_C  = CORDW'(SPEED_X);
  localparam logic signed [CORDW-1:0] YMIN_C  = CORDW'(Y_MIN);
  localparam logic signed [CORDW-1:0] YMAX_C  = CORDW'(Y_MAX);
  localparam logic signed [CORDW-1:0] YINIT_C = CORDW'(Y_INIT);

  // One extra bit so the vertical step can overshoot a limit without wrapping.
  localparam int YW = CORDW + 1;
  localparam logic signed [YW-1:0] YMIN_W = YW'(Y_MIN);
  localparam logic signed [YW-1:0] YMAX_W = YW'(Y_MAX);
  localparam logic signed [YW-1:0] SPDY_W = YW'(SPEED_Y);

  localparam logic [ADDRW-1:0] ADDR_F1 = ADDRW'(SPR_PIXELS);
  localparam logic [ADDRW-1:0] ADDR_F2 = ADDRW'(2 * SPR_PIXELS);

  state_t                  state_q;
  logic                    dir_q;
  logic [5:0]              cnt_q, cnt_d;
  logic signed [CORDW-1:0] sprx_q, sprx_d;
  logic signed [CORDW-1:0] spry_q, spry_d;
  logic [ADDRW-1:0]        addr_q, addr_d;
  logic                    flip_q;
  logic                    walking_q;

  logic signed [YW-1:0]    y_up, y_dn;
  logic [5:0]              cnt_inc;

  always_comb begin
    sprx_d = sprx_q;
    case (state_q)
      WALK_L:  sprx_d = (sprx_q > XMIN_C) ? sprx_q - SPDX_C : XMAX_C;
      WALK_R:  sprx_d = (sprx_q < XMAX_C) ? sprx_q + SPDX_C : XMIN_C;
      default: sprx_d = sprx_q;
    endcase
  end

  always_comb begin
    y_up   = {spry_q[CORDW-1], spry_q} - SPDY_W;
    y_dn   = {spry_q[CORDW-1], spry_q} + SPDY_W;
    spry_d = spry_q;
    if (move_up && !move_dn) begin
      spry_d = (y_up < YMIN_W) ? YMIN_C : y_up[CORDW-1:0];
    end else if (move_dn && !move_up) begin
      spry_d = (y_dn > YMAX_W) ? YMAX_C : y_dn[CORDW-1:0];
    end
  end

  // Graphic sequence over 64 frames: stand, step A, stand, step B.
  always_comb begin
    cnt_inc = cnt_q + 6'd1;
    cnt_d   = 6'd0;
    addr_d  = '0;
    if (state_q != STOP) begin
      cnt_d = cnt_inc;
      case (cnt_inc[5:4])
        2'b01:   addr_d = ADDR_F1;
        2'b11:   addr_d = ADDR_F2;
        default: addr_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WALK_L;
      dir_q     <= 1'b0;
      cnt_q     <= 6'd0;
      sprx_q    <= XMAX_C;
      spry_q    <= YINIT_C;
      addr_q    <= '0;
      flip_q    <= 1'b0;
      walking_q <= 1'b1;
    end else begin
      if (frame) begin
        sprx_q <= sprx_d;
        spry_q <= spry_d;
        cnt_q  <= cnt_d;
        addr_q <= addr_d;
      end
      if (sig_ctrl) begin
        case (state_q)
          WALK_L, WALK_R: begin
            state_q   <= STOP;
            walking_q <= 1'b0;
          end
          STOP: begin
            // Resume in the opposite direction to the last walk.
            state_q   <= dir_q ? WALK_L : WALK_R;
            dir_q     <= ~dir_q;
            flip_q    <= ~dir_q;
            walking_q <= 1'b1;
          end
          default: begin
            state_q   <= STOP;
            walking_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sprx          = sprx_q;
  assign spry          = spry_q;
  assign spr_base_addr = addr_q;
  assign flip          = flip_q;
  assign walking       = walking_q;

endmodule

// File: tb/tb_sprite_ctrl.sv
// Bench for sprite_ctrl: directed walk/wrap/animation/clamp scenarios followed by
// random stimulus, every cycle compared against an integer reference model.
module tb_sprite_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, frame = 1'b0, move_up = 1'b0, move_dn = 1'b0, sig_ctrl = 1'b0;
  logic signed [15:0] sprx, spry;
  logic [11:0] spr_base_addr;
  logic flip, walking;

  sprite_ctrl dut (
    .clk(clk), .rst(rst), .frame(frame), .move_up(move_up), .move_dn(move_dn),
    .sig_ctrl(sig_ctrl), .sprx(sprx), .spry(spry), .spr_base_addr(spr_base_addr),
    .flip(flip), .walking(walking)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integers; moving = -1/+1/0 for left/right/stopped.
  int m_x, m_y, m_frames, m_addr, m_move, m_last;

  function automatic int pose_addr(input int frames_walked);
    int ph;
    ph = frames_walked % 64;
    if (ph >= 48) return 1280;
    if (ph >= 16 && ph < 32) return 640;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit f, input bit s, input bit u, input bit d);
    if (r) begin
      m_x = 640; m_y = 200; m_frames = 0; m_addr = 0; m_move = -1; m_last = -1;
      return;
    end
    if (f) begin
      if (m_move < 0) m_x = (m_x > -132) ? m_x - 2 : 640;
      else if (m_move > 0) m_x = (m_x < 640) ? m_x + 2 : -132;
      if (u && !d) m_y = (m_y - 2 < 0) ? 0 : m_y - 2;
      if (d && !u) m_y = (m_y + 2 > 400) ? 400 : m_y + 2;
      if (m_move != 0) begin
        m_frames = m_frames + 1;
        m_addr = pose_addr(m_frames);
      end else begin
        m_frames = 0;
        m_addr = 0;
      end
    end
    if (s) begin
      if (m_move != 0) m_move = 0;
      else begin
        m_move = -m_last;
        m_last = m_move;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit f, input bit s, input bit u, input bit d);
    rst = r; frame = f; sig_ctrl = s; move_up = u; move_dn = d;
    @(posedge clk);
    model_step(r, f, s, u, d);
    #1;
    check("sprx", $signed(sprx), m_x);
    check("spry", $signed(spry), m_y);
    check("addr", {20'd0, spr_base_addr}, m_addr);
    check("flip", {31'd0, flip}, (m_last > 0) ? 1 : 0);
    check("walking", {31'd0, walking}, (m_move != 0) ? 1 : 0);
  endtask

  int x0, k;
  bit ru, rd;

  initial begin
    // Reset and first frame
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_walking", {31'd0, walking}, 1);
    cyc(0, 1, 0, 0, 0);
    check("rst_sprx", $signed(sprx), 638);
    check("rst_spry", $signed(spry), 200);
    check("rst_addr", {20'd0, spr_base_addr}, 0);
    check("rst_flip", {31'd0, flip}, 0);

    // Left wrap
    for (int i = 0; i < 385; i++) cyc(0, 1, 0, 0, 0);
    check("lwrap_min", $signed(sprx), -132);
    cyc(0, 1, 0, 0, 0);
    check("lwrap_jump", $signed(sprx), 640);

    // Animation sequence from reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      cyc(0, 1, 0, 0, 0);
      check("anim", {20'd0, spr_base_addr},
            (i < 16) ? 0 : (i < 32) ? 640 : (i < 48) ? 0 : (i < 64) ? 1280 : 0);
    end

    // Stop, then resume reversed
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("stop_walking", {31'd0, walking}, 0);
    x0 = sprx;
    cyc(0, 1, 0, 0, 0);
    check("stop_hold", $signed(sprx), x0);
    check("stop_addr", {20'd0, spr_base_addr}, 0);
    cyc(0, 0, 1, 0, 0);
    check("resume_flip", {31'd0, flip}, 1);
    check("resume_walking", {31'd0, walking}, 1);
    cyc(0, 1, 0, 0, 0);
    check("right_step1", $signed(sprx), x0 + 2);
    cyc(0, 1, 0, 0, 0);
    check("right_step2", $signed(sprx), x0 + 4);

    // Right wrap
    k = 0;
    while ($signed(sprx) != 640 && k < 500) begin
      cyc(0, 1, 0, 0, 0);
      k++;
    end
    check("rwrap_reach", $signed(sprx), 640);
    cyc(0, 1, 0, 0, 0);
    check("rwrap_jump", $signed(sprx), -132);

    // Vertical clamps
    for (int i = 0; i < 110; i++) cyc(0, 1, 0, 1, 0);
    check("yclamp_top", $signed(spry), 0);
    cyc(0, 1, 0, 1, 1);
    check("y_both_hold", $signed(spry), 0);
    for (int i = 0; i < 210; i++) cyc(0, 1, 0, 0, 1);
    check("yclamp_bot", $signed(spry), 400);
    cyc(0, 1, 0, 0, 1);
    check("yclamp_bot_hold", $signed(spry), 400);

    // Reset together with frame, then stop on a frame cycle
    cyc(1, 1, 1, 1, 0);
    check("rst_frame_sprx", $signed(sprx), 640);
    check("rst_frame_spry", $signed(spry), 200);
    cyc(0, 1, 1, 0, 0);
    check("stop_frame_sprx", $signed(sprx), 638);
    check("stop_frame_walk", {31'd0, walking}, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("stop_frame_hold", $signed(sprx), 638);

    // Random stimulus
    ru = 0; rd = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(15) == 0) begin
        ru = $urandom_range(1);
        rd = $urandom_range(1);
      end
      cyc($urandom_range(999) == 0, $urandom_range(1) == 1, $urandom_range(39) == 0, ru, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
